seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of consecutive cycles a selector value must hold before led_data is sampled (range 1..15).
REQ-002 Parameter STABLE_FRAMES, default 2, is the number of consecutive identical frames required before commit when filtering is compiled in (range 1..7).
REQ-003 Port clk, input, 1, is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port button_rst, input, 1, is the asynchronous active-high reset.
REQ-005 Port led_selector, input, 4, is the digit select from the display driver: one-hot active-high, bit0 = digit0; 4'b0000 is a blanking gap.
REQ-006 Port led_data, input, 8, carries the segments: bit7 = dp, bits6:0 = g..a, active-high.
REQ-007 Port digits, output, 16, holds the committed hex codes, digit0 in bits 3:0.
REQ-008 Port dps, output, 4, holds the committed decimal points.
REQ-009 Port blanks, output, 4, flags committed digits whose segments are all off.
REQ-010 Port frame_valid, output, 1, is a one-cycle pulse on each commit.
REQ-011 Ports sel_error and seg_error, output, 1 each, are one-cycle error pulses.

Function
REQ-012 States: IDLE (wait for digit0), SCAN (collect digits 1..3 in order), DONE (one cycle: compare/commit, then SCAN expecting digit0).
REQ-013 led_selector SHALL be registered once; change detection and settle counting SHALL use the registered value.
REQ-014 A one-hot selector held SETTLE_CYCLES cycles SHALL sample led_data exactly once into its slot; holding it longer SHALL NOT resample.
REQ-015 Blanking gaps (4'b0000) SHALL be ignored and SHALL reset the settle counter.
REQ-016 A non-one-hot, non-zero selector held SETTLE_CYCLES cycles SHALL pulse sel_error, discard the partial frame, and return to IDLE.
REQ-017 A settled digit other than the expected index SHALL pulse sel_error and discard the partial frame; a settled digit0 SHALL restart collection at slot 0.
REQ-018 The expected index SHALL be 0 in IDLE, advance 0->1->2->3, then DONE, then wrap to 0.
REQ-019 The decode SHALL use the standard 7-segment table for 0-9 and A-F (A,b,C,d,E,F): 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F.
REQ-020 A blank (0x00) SHALL decode to code 0 with the blank flag set.
REQ-021 Any other pattern SHALL decode to code 0, pulse seg_error in the sample cycle, and the frame SHALL still complete.
REQ-022 The commit SHALL update digits, dps and blanks together and pulse frame_valid in the cycle after DONE; the outputs SHALL hold between commits.
REQ-023 A frame containing a seg_error digit SHALL NOT be committed.
REQ-024 sel_error and seg_error arising in the same cycle SHALL both pulse.

Reset
REQ-025 On button_rst: state IDLE; counters, slots, digits, dps and blanks SHALL be 0; all pulses SHALL be 0.
REQ-026 Asserting reset mid-frame SHALL discard the partial frame.
REQ-027 The first frame after deassertion SHALL start only at a settled digit0.

Configuration
REQ-028 With SEG_SCAN_STABLE_FILTER_EN defined, a frame (codes, dps, blanks) SHALL commit only after STABLE_FRAMES consecutive identical complete frames.
REQ-029 With SEG_SCAN_STABLE_FILTER_EN defined, a differing frame SHALL restart the match count at 1.
REQ-030 With SEG_SCAN_STABLE_FILTER_EN defined, an error or discard SHALL clear the match count.
REQ-031 Without SEG_SCAN_STABLE_FILTER_EN, every complete error-free frame SHALL commit, and STABLE_FRAMES SHALL be ignored.

Structure
REQ-032 The segment patterns, dp bit index and state encodings SHALL live in a shared package/include alongside global_define.v, so the display driver and this block use one table.
REQ-033 The combinational pattern-to-code decode SHALL be a sub-module named seg7_to_hex (in: 7 segments; out: code, blank, illegal).

Verification
REQ-034 Reset pulse, then frame 0x3F,0x06,0x5B,0x4F (4 cycles each, 2-cycle gaps) repeated 2x -> digits=16'h3210 and one frame_valid pulse after frame 2 (filter on).
REQ-035 Same stimulus with the filter compiled out -> commit after frame 1 and again after frame 2.
REQ-036 Selector 4'b0011 held 3 cycles mid-frame -> one sel_error pulse, no commit, resync at next digit0.
REQ-037 Sequence digit0, digit2 -> sel_error; the outputs keep their previous values.
REQ-038 Digit1 = 0x80|0x6D, digit3 = 0x00 -> dps=4'b0010, blanks=4'b1000, digit1 code 5.
REQ-039 Digit2 = 0x55 -> seg_error pulse, no commit; button_rst mid-frame -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared 7-segment table, dp bit index and scan FSM encoding for seg_scan_decoder.
package seg_scan_decoder_pkg;

    localparam int unsigned DpBit = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Segment bits 6:0 = g..a, active-high.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex code decode with blank/illegal flags.
module seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       blank_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = 4'h0;
        blank_o   = (seg_i == 7'h00);
        illegal_o = (seg_i != 7'h00);
        for (int i = 0; i < 16; i++) begin
            if (seg_i == seg_pattern(4'(i))) begin
                code_o    = 4'(i);
                illegal_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment drive. Optional stability filter
// enabled by defining SEG_SCAN_STABLE_FILTER_EN.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        button_rst,
    input  logic [3:0]  led_selector,
    input  logic [7:0]  led_data,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blanks,
    output logic        frame_valid,
    output logic        sel_error,
    output logic        seg_error
);

    localparam logic [3:0] Settle = 4'(SETTLE_CYCLES);

    logic [3:0]  sel_q, held_q, run_q, run_d;
    logic [7:0]  data_q;
    state_e      state_q, state_d;
    logic [1:0]  exp_q, exp_d, idx;
    logic [15:0] frm_code_q, frm_code_d, digits_q, digits_d;
    logic [3:0]  frm_dp_q, frm_dp_d, frm_blank_q, frm_blank_d;
    logic [3:0]  dps_q, dps_d, blanks_q, blanks_d;
    logic        bad_q, bad_d;
    logic        frame_valid_q, frame_valid_d;
    logic        sel_err_q, sel_err_d, seg_err_q, seg_err_d;
    logic        same, fire, one_hot, take, commit;
    logic [3:0]  dec_code;
    logic        dec_blank, dec_illegal;

`ifdef SEG_SCAN_STABLE_FILTER_EN
    localparam logic [2:0] Stable = 3'(STABLE_FRAMES);
    logic [2:0]  match_q, match_d;
    logic [23:0] ref_q, ref_d;
    logic [23:0] frame;
    assign frame = {frm_code_q, frm_dp_q, frm_blank_q};
`else
    logic unused_stable;
    assign unused_stable = ^{1'(STABLE_FRAMES)};
`endif

    seg7_to_hex u_dec (
        .seg_i     (data_q[6:0]),
        .code_o    (dec_code),
        .blank_o   (dec_blank),
        .illegal_o (dec_illegal)
    );

    // Fire exactly once when the registered selector reaches SETTLE_CYCLES.
    assign same    = (sel_q == held_q);
    assign one_hot = $onehot(sel_q);

    always_comb begin
        if (sel_q == 4'b0000) begin
            run_d = 4'd0;
        end else if (!same) begin
            run_d = 4'd1;
        end else if (run_q == Settle) begin
            run_d = Settle;
        end else begin
            run_d = run_q + 4'd1;
        end
    end

    assign fire = (sel_q != 4'b0000) && (run_d == Settle) && !(same && (run_q == Settle));

    always_comb begin
        case (sel_q)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        frm_code_d    = frm_code_q;
        frm_dp_d      = frm_dp_q;
        frm_blank_d   = frm_blank_q;
        bad_d         = bad_q;
        digits_d      = digits_q;
        dps_d         = dps_q;
        blanks_d      = blanks_q;
        frame_valid_d = 1'b0;
        sel_err_d     = 1'b0;
        seg_err_d     = 1'b0;
        take          = 1'b0;
        commit        = 1'b0;
`ifdef SEG_SCAN_STABLE_FILTER_EN
        match_d       = match_q;
        ref_d         = ref_q;
`endif

        if (state_q == StDone) begin
            state_d = StScan;
`ifdef SEG_SCAN_STABLE_FILTER_EN
            if (bad_q) begin
                match_d = 3'd0;
            end else if ((match_q != 3'd0) && (frame == ref_q)) begin
                match_d = (match_q >= Stable) ? Stable : match_q + 3'd1;
            end else begin
                match_d = 3'd1;
                ref_d   = frame;
            end
            commit = !bad_q && (match_d >= Stable);
`else
            commit = !bad_q;
`endif
        end

        if (commit) begin
            digits_d      = frm_code_q;
            dps_d         = frm_dp_q;
            blanks_d      = frm_blank_q;
            frame_valid_d = 1'b1;
        end

        if (fire) begin
            if (!one_hot) begin
                sel_err_d = 1'b1;
                state_d   = StIdle;
                exp_d     = 2'd0;
            end else if (state_q == StIdle) begin
                take = (idx == 2'd0);
            end else if (idx == exp_q) begin
                take = 1'b1;
            end else if (idx == 2'd0) begin
                sel_err_d = 1'b1;
                take      = 1'b1;
            end else begin
                sel_err_d = 1'b1;
                state_d   = StIdle;
                exp_d     = 2'd0;
            end
        end

        if (take) begin
            frm_code_d[{idx, 2'b00} +: 4] = dec_code;
            frm_dp_d[idx]    = data_q[DpBit];
            frm_blank_d[idx] = dec_blank;
            seg_err_d        = dec_illegal;
            bad_d            = ((idx == 2'd0) ? 1'b0 : bad_q) | dec_illegal;
            if (idx == 2'd3) begin
                state_d = StDone;
                exp_d   = 2'd0;
            end else begin
                state_d = StScan;
                exp_d   = idx + 2'd1;
            end
        end

`ifdef SEG_SCAN_STABLE_FILTER_EN
        if (sel_err_d) begin
            match_d = 3'd0;
        end
`endif
    end

    always_ff @(posedge clk or posedge button_rst) begin
        if (button_rst) begin
            sel_q         <= 4'd0;
            held_q        <= 4'd0;
            data_q        <= 8'd0;
            run_q         <= 4'd0;
            state_q       <= StIdle;
            exp_q         <= 2'd0;
            frm_code_q    <= 16'd0;
            frm_dp_q      <= 4'd0;
            frm_blank_q   <= 4'd0;
            bad_q         <= 1'b0;
            digits_q      <= 16'd0;
            dps_q         <= 4'd0;
            blanks_q      <= 4'd0;
            frame_valid_q <= 1'b0;
            sel_err_q     <= 1'b0;
            seg_err_q     <= 1'b0;
`ifdef SEG_SCAN_STABLE_FILTER_EN
            match_q       <= 3'd0;
            ref_q         <= 24'd0;
`endif
        end else begin
            sel_q         <= led_selector;
            held_q        <= sel_q;
            data_q        <= led_data;
            run_q         <= run_d;
            state_q       <= state_d;
            exp_q         <= exp_d;
            frm_code_q    <= frm_code_d;
            frm_dp_q      <= frm_dp_d;
            frm_blank_q   <= frm_blank_d;
            bad_q         <= bad_d;
            digits_q      <= digits_d;
            dps_q         <= dps_d;
            blanks_q      <= blanks_d;
            frame_valid_q <= frame_valid_d;
            sel_err_q     <= sel_err_d;
            seg_err_q     <= seg_err_d;
`ifdef SEG_SCAN_STABLE_FILTER_EN
            match_q       <= match_d;
            ref_q         <= ref_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign dps         = dps_q;
    assign blanks      = blanks_q;
    assign frame_valid = frame_valid_q;
    assign sel_error   = sel_err_q;
    assign seg_error   = seg_err_q;

endmodule
